// File: rtl/ps2_scan_history_pkg.sv
// Shared types and constants for the PS/2 scan-code history receiver.
package ps2_scan_history_pkg;

   // state     | meaning
   // ST_IDLE   | line idle, waiting for a start bit (D=0 on a PS2C fall)
   // ST_DATA   | shifting in the 8 data bits, LSB first
   // ST_PARITY | waiting for the odd-parity bit
   // ST_STOP   | waiting for the stop bit, then accept or drop the frame
   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_DATA   = 2'd1,
      ST_PARITY = 2'd2,
      ST_STOP   = 2'd3
   } ps2_state_t;

   localparam logic [7:0] PS2_BREAK_CODE = 8'hF0;
   localparam logic [7:0] PS2_EXT_CODE   = 8'hE0;
   localparam int         PS2_DATA_BITS  = 8;

endpackage

// File: rtl/ps2_scan_history_line_filter.sv
// PS2C line conditioning: 2-FF synchroniser, stability deglitcher and a
// one-cycle strobe on each falling edge of the filtered level.
// The filtered level only follows the synchronised line after it has
// differed from it for FILTER_LEN consecutive cycles (down-counter to zero).
module ps2_scan_history_line_filter #(
   parameter int FILTER_LEN = 8
) (
   input  logic i_clk,
   input  logic i_rst,
   input  logic i_line,
   output logic o_fall
);

   localparam int             CW     = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
   localparam logic [CW-1:0]  RELOAD = CW'(FILTER_LEN - 1);

   logic          r_s1;
   logic          r_s2;
   logic          r_filt;
   logic [CW-1:0] r_cnt;
   logic          r_fall;

   // Synchronise, deglitch and detect the high-to-low transition of the filtered level.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_s1   <= 1'b1;
         r_s2   <= 1'b1;
         r_filt <= 1'b1;
         r_cnt  <= RELOAD;
         r_fall <= 1'b0;
      end else begin
         r_s1   <= i_line;
         r_s2   <= r_s1;
         r_fall <= 1'b0;
         if (r_s2 == r_filt) begin
            r_cnt <= RELOAD;
         end else if (r_cnt == '0) begin
            r_filt <= r_s2;
            r_cnt  <= RELOAD;
            r_fall <= r_filt & ~r_s2;
         end else begin
            r_cnt <= r_cnt - 1'b1;
         end
      end
   end

   assign o_fall = r_fall;

endmodule

// File: rtl/ps2_scan_history.sv
// PS/2 keyboard receiver with a shift history of the last HIST_BYTES bytes.
// Frames: start, 8 data bits LSB first, odd parity, stop; mid-frame timeout.
// Optional build macro PS2_BREAK_FILTER_EN: keep 8'hF0 and the byte that
// follows it out of the history (they are still reported on o_Byte/o_Valid).
// HIST_BYTES must be at least 2.
module ps2_scan_history
   import ps2_scan_history_pkg::*;
#(
   parameter int HIST_BYTES  = 3,
   parameter int FILTER_LEN  = 8,
   parameter int TIMEOUT_CYC = 50000
) (
   input  logic                            i_clk,
   input  logic                            i_rst,
   input  logic                            i_PS2C,
   input  logic                            i_PS2D,
   input  logic                            i_Clear,
   output logic [8*HIST_BYTES-1:0]         o_Data,
   output logic [7:0]                      o_Byte,
   output logic                            o_Valid,
   output logic                            o_ParityErr,
   output logic                            o_FrameErr,
   output logic [$clog2(HIST_BYTES+1)-1:0] o_Count
);

   localparam int            DW       = 8 * HIST_BYTES;
   localparam int            CNTW     = $clog2(HIST_BYTES + 1);
   localparam int            TW       = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
   localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYC - 1);

   logic          r_d_s1;
   logic          r_d_s2;
   logic          w_strobe;

   ps2_state_t    r_state;
   ps2_state_t    w_state_nxt;
   logic [2:0]    r_bit_cnt;
   logic [2:0]    w_bit_cnt_nxt;
   logic [7:0]    r_shift;
   logic [7:0]    w_shift_nxt;
   logic          r_parity;
   logic          w_parity_nxt;
   logic [TW-1:0] r_tmo;
   logic          w_tmo_hit;

   logic          w_accept;
   logic          w_perr;
   logic          w_ferr;
   logic          w_push;

   ps2_scan_history_line_filter #(
      .FILTER_LEN (FILTER_LEN)
   ) u_clk_filter (
      .i_clk  (i_clk),
      .i_rst  (i_rst),
      .i_line (i_PS2C),
      .o_fall (w_strobe)
   );

   // PS2D only needs synchronising: it is sampled long after it settles.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_d_s1 <= 1'b1;
         r_d_s2 <= 1'b1;
      end else begin
         r_d_s1 <= i_PS2D;
         r_d_s2 <= r_d_s1;
      end
   end

   // Mid-frame watchdog: reloads on every strobe, expires at zero.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_tmo <= '0;
      end else if (r_state == ST_IDLE || w_strobe) begin
         r_tmo <= TMO_LOAD;
      end else if (r_tmo != '0) begin
         r_tmo <= r_tmo - 1'b1;
      end
   end

   assign w_tmo_hit = (r_state != ST_IDLE) && !w_strobe && (r_tmo == '0);

   // Frame FSM state and datapath registers.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_state   <= ST_IDLE;
         r_bit_cnt <= '0;
         r_shift   <= '0;
         r_parity  <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_bit_cnt <= w_bit_cnt_nxt;
         r_shift   <= w_shift_nxt;
         r_parity  <= w_parity_nxt;
      end
   end

   // Next-state decode; a timeout overrides everything and discards the partial byte.
   always_comb begin
      w_state_nxt   = r_state;
      w_bit_cnt_nxt = r_bit_cnt;
      w_shift_nxt   = r_shift;
      w_parity_nxt  = r_parity;
      w_accept      = 1'b0;
      w_perr        = 1'b0;
      w_ferr        = 1'b0;
      if (w_tmo_hit) begin
         w_state_nxt = ST_IDLE;
         w_ferr      = 1'b1;
      end else if (w_strobe) begin
         case (r_state)
            ST_IDLE: begin
               if (!r_d_s2) begin
                  w_state_nxt   = ST_DATA;
                  w_bit_cnt_nxt = '0;
               end
            end
            ST_DATA: begin
               w_shift_nxt   = {r_d_s2, r_shift[7:1]};
               w_bit_cnt_nxt = r_bit_cnt + 3'd1;
               if (r_bit_cnt == 3'(PS2_DATA_BITS - 1)) begin
                  w_state_nxt = ST_PARITY;
               end
            end
            ST_PARITY: begin
               w_parity_nxt = r_d_s2;
               w_state_nxt  = ST_STOP;
            end
            ST_STOP: begin
               w_state_nxt = ST_IDLE;
               if (r_d_s2 && (^{r_shift, r_parity})) begin
                  w_accept = 1'b1;
               end else begin
                  w_perr = 1'b1;
               end
            end
            default: w_state_nxt = ST_IDLE;
         endcase
      end
   end

`ifdef PS2_BREAK_FILTER_EN
   logic r_brk_pend;

   // Break code arms a one-byte skip; the byte after it clears the flag.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         r_brk_pend <= 1'b0;
      end else if (i_Clear) begin
         r_brk_pend <= 1'b0;
      end else if (w_accept) begin
         r_brk_pend <= !r_brk_pend && (r_shift == PS2_BREAK_CODE);
      end
   end

   assign w_push = w_accept && !r_brk_pend && (r_shift != PS2_BREAK_CODE);
`else
   assign w_push = w_accept;
`endif

   // Registered outputs: pulses, last byte and the history shift register.
   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         o_Valid     <= 1'b0;
         o_ParityErr <= 1'b0;
         o_FrameErr  <= 1'b0;
         o_Byte      <= '0;
         o_Data      <= '0;
         o_Count     <= '0;
      end else begin
         o_Valid     <= w_accept;
         o_ParityErr <= w_perr;
         o_FrameErr  <= w_ferr;
         if (w_accept) begin
            o_Byte <= r_shift;
         end
         if (i_Clear) begin
            o_Data  <= w_push ? {{(DW-8){1'b0}}, r_shift} : '0;
            o_Count <= w_push ? CNTW'(1) : '0;
         end else if (w_push) begin
            o_Data <= {o_Data[DW-9:0], r_shift};
            if (o_Count != CNTW'(HIST_BYTES)) begin
               o_Count <= o_Count + 1'b1;
            end
         end
      end
   end

endmodule
